mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single multi-cycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between the pipelined cache control and the 4-cycle-latency pipelined memory.
- Sequences an 8-word block fill and streams the returned words to the selected cache's data array.
- Pulses a completion strobe so the cache can write its tag and release its stall.

Parameters:
WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of 2)
MEM_LATENCY, 4, cycles from mem_en to mem_data_valid for a read
ADDR_W, 16, byte address width
DATA_W, 16, data word width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  I-cache miss request, held until i_done
i_addr  in  16  I-cache miss byte address
d_req  in  1  D-cache miss request, held until d_done
d_addr  in  16  D-cache miss byte address
d_wr_req  in  1  D-cache write-through request, held until d_wr_done
d_wr_addr  in  16  store byte address
d_wr_data  in  16  store data
i_grant  out  1  I-cache owns memory (fill in progress)
d_grant  out  1  D-cache owns memory (fill or write)
fill_data  out  16  returned word, shared by both caches
fill_idx  out  3  word index within block for fill_data
i_fill_we  out  1  write fill_data into I-cache word fill_idx
d_fill_we  out  1  write fill_data into D-cache word fill_idx
i_done  out  1  one-cycle pulse, I fill complete
d_done  out  1  one-cycle pulse, D fill complete
d_wr_done  out  1  one-cycle pulse, store accepted
mem_en  out  1  memory access enable
mem_wr  out  1  memory write (1) / read (0)
mem_addr  out  16  memory byte address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data
mem_data_valid  in  1  mem_rdata valid
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, both counters 0, owner cleared. All outputs 0.
- States: IDLE, FILL, WRITE.
- IDLE priority: d_wr_req > d_req > i_req.
  - d_wr_req → WRITE.
  - d_req / i_req → FILL, latching the base address addr[15:4] and the owner.
  - Decision is registered; grant asserts the cycle after the request is seen.
- WRITE: one cycle.
  - mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_grant=1.
  - d_wr_done=1 in the same cycle; next state IDLE.
- FILL issue:
  - issue_cnt runs 0..7. Each cycle while issue_cnt<8: mem_en=1, mem_wr=0, mem_addr={base,issue_cnt,1'b0}, then issue_cnt++.
  - Reads are issued back-to-back in 8 consecutive cycles.
- FILL receive:
  - recv_cnt runs 0..7 and increments on every mem_data_valid.
  - On each mem_data_valid: fill_data=mem_rdata, fill_idx=recv_cnt, owner's *_fill_we=1.
  - Words are returned in issue order.
  - Last word (recv_cnt==7 with valid): the owner's *_done pulses in the same cycle as the final fill_we. Next state IDLE and counters clear.
- Fill latency: first fill_we at MEM_LATENCY cycles after the first issue. Done = grant cycle + 8 + MEM_LATENCY − 1.
- Grants:
  - i_grant/d_grant stay high for the whole FILL/WRITE.
  - The owner does not change mid-operation.
  - A new request seen in the done cycle is serviced starting the next IDLE cycle. This gives a one-cycle IDLE gap minimum between operations.
- Request withdrawal mid-FILL is ignored; the fill runs to completion.
- mem_data_valid in IDLE or WRITE is ignored: no fill_we.
- Simultaneous d_req and i_req: D served first. I waits and is served in the next IDLE decision if still asserted.
- Reset mid-FILL: return to IDLE next edge. Later valids from in-flight reads are dropped, and no done pulse is produced.
- Counters are log2(WORDS_PER_BLOCK)+1 bits. The address index wraps modulo WORDS_PER_BLOCK.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - FILL latches the start index s=addr[3:1].
  - Issue order is word (s+k) mod 8 for k=0..7.
  - fill_idx follows the same order: the first returned word is the missed word.
  - done timing is unchanged.
- Undefined: issue order always starts at word 0; addr[3:1] is ignored.

Test Plan:
- Idle reset: assert rst 2 cycles with all requests high. All outputs 0 during reset. d_wr_done pulses first after release.
- I fill, i_addr=0x0036, memory word n = 0xA000+n:
  - mem_addr issues 0x0030..0x003E over 8 cycles.
  - i_fill_we fills idx 0..7 with 0xA018..0xA01F.
  - i_done on the 8th valid, 11 cycles after i_grant.
- Contention: d_req (0x1000) and i_req (0x2000) in the same cycle:
  - D fill completes with d_done.
  - One IDLE cycle follows, then i_grant; I fill completes.
  - No cross-asserted fill_we.
- Store priority: d_wr_req (0x0040, 0xBEEF) with i_req pending:
  - WRITE cycle first: mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_wr_done=1.
  - I fill follows.
- Reset mid-fill: rst at the 5th receive cycle of a D fill.
  - IDLE next cycle; no d_done.
  - Remaining valids produce no d_fill_we.
  - A fresh d_req completes normally.
- CRITICAL_WORD_FIRST_EN defined, i_addr=0x003A:
  - Issue order 0x3A,0x3C,0x3E,0x30..0x38.
  - fill_idx sequence 5,6,7,0,1,2,3,4.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Handshake and memory bus bundle between the cache controllers, the arbiter and main memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 3
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              i_grant;
    logic              d_grant;
    logic [DATA_W-1:0] fill_data;
    logic [IDX_W-1:0]  fill_idx;
    logic              i_fill_we;
    logic              d_fill_we;
    logic              i_done;
    logic              d_done;
    logic              d_wr_done;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_valid;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_data_valid,
        output i_grant, d_grant, fill_data, fill_idx, i_fill_we, d_fill_we,
        output i_done, d_done, d_wr_done,
        output mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    // Environment side: caches and memory.
    modport master (
        output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
        output mem_rdata, mem_data_valid,
        input  i_grant, d_grant, fill_data, fill_idx, i_fill_we, d_fill_we,
        input  i_done, d_done, d_wr_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: D store > D fill > I fill, block fills streamed to the owning cache.
// Optional macro CRITICAL_WORD_FIRST_EN starts each fill at the missed word.
module mem_arbiter #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned MEM_LATENCY     = 4,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned BASE_W = ADDR_W - IDX_W - 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WRITE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    issue_q, issue_d;
    logic [CNT_W-1:0]    recv_q, recv_d;
    // Marks which memory pipeline slots carry reads of the current fill.
    logic [MEM_LATENCY-1:0] inflight_q;
`ifdef CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0]    start_q, start_d;
`endif

    logic [ADDR_W-1:0]   req_addr;
    logic [IDX_W-1:0]    issue_idx;
    logic [IDX_W-1:0]    recv_idx;
    logic                issue_fire_c;
    logic                unused_addr_bits;

    logic                i_grant_c, d_grant_c;
    logic [DATA_W-1:0]   fill_data_c;
    logic [IDX_W-1:0]    fill_idx_c;
    logic                i_fill_we_c, d_fill_we_c;
    logic                i_done_c, d_done_c, d_wr_done_c;
    logic                mem_en_c, mem_wr_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   mem_wdata_c;
    logic                busy_c;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_I;
            base_q     <= '0;
            issue_q    <= '0;
            recv_q     <= '0;
            inflight_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            base_q     <= base_d;
            issue_q    <= issue_d;
            recv_q     <= recv_d;
            inflight_q <= {inflight_q[MEM_LATENCY-2:0], issue_fire_c};
`ifdef CRITICAL_WORD_FIRST_EN
            start_q    <= start_d;
`endif
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    assign issue_idx = issue_q[IDX_W-1:0] + start_q;
    assign recv_idx  = recv_q[IDX_W-1:0] + start_q;
`else
    assign issue_idx = issue_q[IDX_W-1:0];
    assign recv_idx  = recv_q[IDX_W-1:0];
`endif

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        base_d       = base_q;
        issue_d      = issue_q;
        recv_d       = recv_q;
`ifdef CRITICAL_WORD_FIRST_EN
        start_d      = start_q;
`endif
        req_addr     = '0;
        issue_fire_c = 1'b0;
        i_grant_c    = 1'b0;
        d_grant_c    = 1'b0;
        fill_data_c  = '0;
        fill_idx_c   = '0;
        i_fill_we_c  = 1'b0;
        d_fill_we_c  = 1'b0;
        i_done_c     = 1'b0;
        d_done_c     = 1'b0;
        d_wr_done_c  = 1'b0;
        mem_en_c     = 1'b0;
        mem_wr_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        busy_c       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                issue_d = '0;
                recv_d  = '0;
                if (bus.d_wr_req) begin
                    state_d = ST_WRITE;
                    owner_d = OWN_D;
                end else if (bus.d_req || bus.i_req) begin
                    state_d  = ST_FILL;
                    owner_d  = bus.d_req ? OWN_D : OWN_I;
                    req_addr = bus.d_req ? bus.d_addr : bus.i_addr;
                    base_d   = req_addr[ADDR_W-1:IDX_W+1];
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d  = req_addr[IDX_W:1];
`endif
                end
            end
            ST_WRITE: begin
                d_grant_c   = 1'b1;
                mem_en_c    = 1'b1;
                mem_wr_c    = 1'b1;
                mem_addr_c  = bus.d_wr_addr;
                mem_wdata_c = bus.d_wr_data;
                d_wr_done_c = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_FILL: begin
                i_grant_c = (owner_q == OWN_I);
                d_grant_c = (owner_q == OWN_D);
                if (issue_q < CNT_W'(WORDS_PER_BLOCK)) begin
                    mem_en_c     = 1'b1;
                    mem_addr_c   = {base_q, issue_idx, 1'b0};
                    issue_d      = issue_q + CNT_W'(1);
                    issue_fire_c = 1'b1;
                end
                // Only returns matched to this fill's reads are written.
                if (bus.mem_data_valid && inflight_q[MEM_LATENCY-1]) begin
                    fill_data_c = bus.mem_rdata;
                    fill_idx_c  = recv_idx;
                    i_fill_we_c = (owner_q == OWN_I);
                    d_fill_we_c = (owner_q == OWN_D);
                    recv_d      = recv_q + CNT_W'(1);
                    if (recv_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                        i_done_c = (owner_q == OWN_I);
                        d_done_c = (owner_q == OWN_D);
                        state_d  = ST_IDLE;
                        issue_d  = '0;
                        recv_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are held quiet while reset is asserted.
        if (rst) begin
            i_grant_c   = 1'b0;
            d_grant_c   = 1'b0;
            fill_data_c = '0;
            fill_idx_c  = '0;
            i_fill_we_c = 1'b0;
            d_fill_we_c = 1'b0;
            i_done_c    = 1'b0;
            d_done_c    = 1'b0;
            d_wr_done_c = 1'b0;
            mem_en_c    = 1'b0;
            mem_wr_c    = 1'b0;
            mem_addr_c  = '0;
            mem_wdata_c = '0;
            busy_c      = 1'b0;
        end
    end

    assign unused_addr_bits = ^req_addr[IDX_W:0];

    assign bus.i_grant   = i_grant_c;
    assign bus.d_grant   = d_grant_c;
    assign bus.fill_data = fill_data_c;
    assign bus.fill_idx  = fill_idx_c;
    assign bus.i_fill_we = i_fill_we_c;
    assign bus.d_fill_we = d_fill_we_c;
    assign bus.i_done    = i_done_c;
    assign bus.d_done    = d_done_c;
    assign bus.d_wr_done = d_wr_done_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_wr    = mem_wr_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory, fill and done events; a monitor checks them.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if bus ();

    mem_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] wdata;} mem_exp_t;
    typedef struct packed {logic i_we; logic d_we; logic [2:0] idx; logic [15:0] data;} fill_exp_t;
    typedef struct packed {logic [2:0] kind; logic [7:0] lat;} done_exp_t;

    mem_exp_t  mem_q[$];
    fill_exp_t fill_q[$];
    done_exp_t done_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory model: 4-stage read pipeline, word at byte address a returns 0xA000 + a/2.
    logic [3:0]       pv = '0;
    logic [3:0][15:0] pa = '0;
    int               mem_valid_cnt = 0;
    always @(posedge clk) begin
        pv <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
        pa <= {pa[2:0], bus.mem_addr};
        if (pv[2]) mem_valid_cnt <= mem_valid_cnt + 1;
    end
    assign bus.mem_data_valid = pv[3];
    assign bus.mem_rdata      = pv[3] ? (16'hA000 + {1'b0, pa[3][15:1]}) : 16'h0000;

    // Monitor.
    int unsigned cyc = 0;
    int unsigned grant_cyc = 0;
    logic        grant_prev = 1'b0;
    logic        done_prev  = 1'b0;
    always @(negedge clk) begin
        mem_exp_t  me;
        fill_exp_t fe;
        done_exp_t de;
        logic      g;
        cyc++;
        g = bus.i_grant | bus.d_grant;
        if (g && !grant_prev) grant_cyc = cyc;
        grant_prev = g;
        if (done_prev) chk("idle_gap", 32'({bus.busy, bus.i_grant, bus.d_grant}), 32'd0);
        done_prev = bus.i_done | bus.d_done | bus.d_wr_done;
        if (bus.mem_en) begin
            chk("mem_expected", 32'(mem_q.size() > 0), 32'd1);
            if (mem_q.size() > 0) begin
                me = mem_q.pop_front();
                chk("mem_wr", 32'(bus.mem_wr), 32'(me.wr));
                chk("mem_addr", 32'(bus.mem_addr), 32'(me.addr));
                if (me.wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(me.wdata));
            end
        end
        if (bus.i_fill_we || bus.d_fill_we) begin
            chk("fill_expected", 32'(fill_q.size() > 0), 32'd1);
            if (fill_q.size() > 0) begin
                fe = fill_q.pop_front();
                chk("fill_we_owner", 32'({bus.i_fill_we, bus.d_fill_we}), 32'({fe.i_we, fe.d_we}));
                chk("fill_idx", 32'(bus.fill_idx), 32'(fe.idx));
                chk("fill_data", 32'(bus.fill_data), 32'(fe.data));
            end
        end
        if (bus.i_done || bus.d_done || bus.d_wr_done) begin
            chk("done_expected", 32'(done_q.size() > 0), 32'd1);
            if (done_q.size() > 0) begin
                de = done_q.pop_front();
                chk("done_kind", 32'({bus.i_done, bus.d_done, bus.d_wr_done}), 32'(de.kind));
                chk("done_latency", cyc - grant_cyc, 32'(de.lat));
            end
        end
    end

    task automatic push_fill(input logic is_i, input logic [15:0] base, input int n_recv, input bit with_done);
        logic [15:0] a;
        for (int k = 0; k < 8; k++) begin
            a = base + 16'(2 * k);
            mem_q.push_back('{1'b0, a, 16'h0000});
            if (k < n_recv) fill_q.push_back('{is_i, ~is_i, 3'(k), 16'hA000 + {1'b0, a[15:1]}});
        end
        if (with_done) done_q.push_back('{(is_i ? 3'b100 : 3'b010), 8'd11});
    endtask

    task automatic wait_for(input int which, input string name);
        int  n = 0;
        logic seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            case (which)
                0:       seen = bus.d_wr_done;
                1:       seen = bus.d_done;
                default: seen = bus.i_done;
            endcase
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || mem_q.size() != 0 || fill_q.size() != 0 || done_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("idle_reached", 32'(n < 100), 32'd1);
    endtask

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [15:0] IFILL_ADDR = 16'h003A;
    logic [15:0] if_addr_tbl [8] = '{16'h003A, 16'h003C, 16'h003E, 16'h0030, 16'h0032, 16'h0034, 16'h0036, 16'h0038};
    logic [2:0]  if_idx_tbl  [8] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [15:0] if_data_tbl [8] = '{16'hA01D, 16'hA01E, 16'hA01F, 16'hA018, 16'hA019, 16'hA01A, 16'hA01B, 16'hA01C};
`else
    localparam logic [15:0] IFILL_ADDR = 16'h0036;
    logic [15:0] if_addr_tbl [8] = '{16'h0030, 16'h0032, 16'h0034, 16'h0036, 16'h0038, 16'h003A, 16'h003C, 16'h003E};
    logic [2:0]  if_idx_tbl  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [16-1:0] if_data_tbl [8] = '{16'hA018, 16'hA019, 16'hA01A, 16'hA01B, 16'hA01C, 16'hA01D, 16'hA01E, 16'hA01F};
`endif

    initial begin
        int v0;
        int n;
        // Reset with every request raised.
        bus.i_req = 1'b1;    bus.i_addr = 16'h0300;
        bus.d_req = 1'b1;    bus.d_addr = 16'h0200;
        bus.d_wr_req = 1'b1; bus.d_wr_addr = 16'h0100; bus.d_wr_data = 16'h1234;
        mem_q.push_back('{1'b1, 16'h0100, 16'h1234});
        done_q.push_back('{3'b001, 8'd0});
        push_fill(1'b0, 16'h0200, 8, 1'b1);
        push_fill(1'b1, 16'h0300, 8, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs_zero",
                32'({bus.i_grant, bus.d_grant, bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done,
                     bus.d_wr_done, bus.mem_en, bus.mem_wr, bus.busy, (bus.mem_addr != 16'h0)}), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        wait_for(0, "rst_release_store_done");
        bus.d_wr_req = 1'b0;
        wait_for(1, "rst_release_dfill_done");
        bus.d_req = 1'b0;
        wait_for(2, "rst_release_ifill_done");
        bus.i_req = 1'b0;
        wait_idle();

        // I fill with hand-computed addresses and data.
        for (int k = 0; k < 8; k++) begin
            mem_q.push_back('{1'b0, if_addr_tbl[k], 16'h0000});
            fill_q.push_back('{1'b1, 1'b0, if_idx_tbl[k], if_data_tbl[k]});
        end
        done_q.push_back('{3'b100, 8'd11});
        @(posedge clk); #1 bus.i_req = 1'b1; bus.i_addr = IFILL_ADDR;
        wait_for(2, "ifill_done");
        bus.i_req = 1'b0;
        wait_idle();

        // Contention: D before I.
        push_fill(1'b0, 16'h1000, 8, 1'b1);
        push_fill(1'b1, 16'h2000, 8, 1'b1);
        @(posedge clk); #1 bus.d_req = 1'b1; bus.d_addr = 16'h1000; bus.i_req = 1'b1; bus.i_addr = 16'h2000;
        wait_for(1, "contention_d_done");
        bus.d_req = 1'b0;
        wait_for(2, "contention_i_done");
        bus.i_req = 1'b0;
        wait_idle();

        // Store beats a pending I miss.
        mem_q.push_back('{1'b1, 16'h0040, 16'hBEEF});
        done_q.push_back('{3'b001, 8'd0});
        push_fill(1'b1, 16'h0080, 8, 1'b1);
        @(posedge clk); #1 bus.d_wr_req = 1'b1; bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF;
        bus.i_req = 1'b1; bus.i_addr = 16'h0080;
        wait_for(0, "store_done");
        bus.d_wr_req = 1'b0;
        wait_for(2, "store_then_ifill_done");
        bus.i_req = 1'b0;
        wait_idle();

        // Reset on the 5th returned word, then a fresh D fill with d_req still held.
        push_fill(1'b0, 16'h0400, 4, 1'b0);
        push_fill(1'b0, 16'h0400, 8, 1'b1);
        @(posedge clk); #1 bus.d_req = 1'b1; bus.d_addr = 16'h0400;
        v0 = mem_valid_cnt;
        n = 0;
        while (mem_valid_cnt != v0 + 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid_fifth_valid", 32'(mem_valid_cnt - v0), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_quiet", 32'({bus.d_fill_we, bus.d_done, bus.d_grant, bus.busy}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", 32'({bus.busy, bus.i_grant, bus.d_grant}), 32'd0);
        wait_for(1, "rst_mid_fresh_done");
        bus.d_req = 1'b0;
        wait_idle();

        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        chk("fill_q_drained", 32'(fill_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end
endmodule
